// File: rtl/data_mem_ctrl.sv
// Load/store unit: one handshaked access per request to a variable-latency
// data memory, with byte/half/word lane steering, load extension, stall
// generation and misalignment / timeout reporting.
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_misalign_o,
  output logic        err_timeout_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 done_q, done_d;
  logic                 err_mis_q, err_mis_d;
  logic                 err_to_q, err_to_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [3:0]           mem_be_q, mem_be_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic [1:0]           size_q, size_d;
  logic [1:0]           lane_q, lane_d;
  logic                 sext_q, sext_d;

  logic        misalign;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rdata_fmt;

  // Decode alignment, byte enables and replicated store data for a new request.
  always_comb begin
    misalign  = 1'b0;
    be_new    = 4'b0000;
    wdata_new = '0;
    unique case (size_i)
      2'b00: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        misalign  = addr_i[0];
        be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        misalign  = |addr_i[1:0];
        be_new    = 4'b1111;
        wdata_new = wdata_i;
      end
      default: misalign = 1'b1;
    endcase
  end

  // Pick the addressed lane of the returned word and extend it.
  always_comb begin
    rd_byte = 8'h00;
    unique case (lane_q)
      2'd0:    rd_byte = mem_rdata_i[7:0];
      2'd1:    rd_byte = mem_rdata_i[15:8];
      2'd2:    rd_byte = mem_rdata_i[23:16];
      default: rd_byte = mem_rdata_i[31:24];
    endcase
    rd_half   = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    rdata_fmt = mem_rdata_i;
    if (size_q == 2'b00) begin
      rdata_fmt = {{24{sext_q & rd_byte[7]}}, rd_byte};
    end else if (size_q == 2'b01) begin
      rdata_fmt = {{16{sext_q & rd_half[15]}}, rd_half};
    end
  end

  // Next-state logic for the access FSM and all registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_mis_d   = 1'b0;
    err_to_d    = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    size_d      = size_q;
    lane_d      = lane_q;
    sext_d      = sext_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (misalign) begin
            state_d   = StDone;
            done_d    = 1'b1;
            err_mis_d = 1'b1;
            rdata_d   = '0;
          end else begin
            state_d     = StReq;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = we_i;
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_be_d    = be_new;
            mem_wdata_d = wdata_new;
            size_d      = size_i;
            lane_d      = addr_i[1:0];
            sext_d      = sign_ext_i;
          end
        end
      end
      StReq: begin
        // An ack in the final allowed cycle still completes normally.
        if (mem_ack_i) begin
          state_d   = StDone;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d = rdata_fmt;
          end
        end else if (cnt_q == CntMax) begin
          state_d   = StDone;
          done_d    = 1'b1;
          err_to_d  = 1'b1;
          rdata_d   = '0;
          mem_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset discards any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_mis_q   <= 1'b0;
      err_to_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      size_q      <= '0;
      lane_q      <= '0;
      sext_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_mis_q   <= err_mis_d;
      err_to_q    <= err_to_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      sext_q      <= sext_d;
    end
  end

  assign stall_o        = ((state_q == StIdle) && req_valid_i) || (state_q == StReq);
  assign rdata_o        = rdata_q;
  assign done_o         = done_q;
  assign err_misalign_o = err_mis_q;
  assign err_timeout_o  = err_to_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_be_o       = mem_be_q;
  assign mem_wdata_o    = mem_wdata_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Load/store unit that sits directly downstream of the datapath.
- Consumes the ALU result (address) and register store data, performs one handshaked access to a variable-latency data memory, and returns formatted read data.
- Handles byte, half and word accesses with byte enables, lane steering and sign/zero extension.
- Stalls the core until the access finishes, and reports misalignment and memory timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ waiting for mem_ack_i before the access is aborted; must be at least 1.
- CNT_WIDTH, 8: width of the timeout counter; must satisfy 2^CNT_WIDTH >= TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  the current instruction needs a memory access.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- sign_ext_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr_i  in  32  byte address (ALU result).
- wdata_i  in  32  store data (register rd2).
- rdata_o  out  32  formatted load data.
- stall_o  out  1  freeze PC and register writes.
- done_o  out  1  one-cycle completion pulse.
- err_misalign_o  out  1  completion was a misaligned or illegal-size access.
- err_timeout_o  out  1  completion was a timed-out access.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  32  word address, bits [1:0] forced to 00.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_ack_i  in  1  memory accepted the write or returned read data this cycle.
- mem_rdata_i  in  32  read word, valid when mem_ack_i = 1.

Behaviour:
- Reset (asynchronous, rst_ni = 0):
  - State goes to IDLE and the counter clears.
  - All registered outputs go to 0: rdata_o, done_o, err_*, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o.
  - A reset mid-access drops mem_req_o immediately and discards the access; no done_o follows.
- States:
  - IDLE: new requests are accepted only here.
    - req_valid_i = 1 and legal: latch the access, drive the mem_* outputs, go to REQ.
    - req_valid_i = 1 and misaligned/illegal: no memory access; go to DONE with err_misalign_o = 1 and rdata_o = 0.
  - REQ:
    - mem_req_o held at 1 with all mem_* outputs stable until mem_ack_i = 1.
    - On ack: capture the formatted load data (stores leave rdata_o unchanged), drop mem_req_o next cycle, go to DONE.
    - If the counter reaches TIMEOUT_CYCLES-1 with no ack: abort, go to DONE with err_timeout_o = 1 and rdata_o = 0.
    - An ack arriving in the timeout cycle wins and the access completes normally.
  - DONE: done_o = 1 (with any error flag) for exactly one cycle, then IDLE. req_valid_i is ignored in DONE.
- stall_o is combinational: 1 when (IDLE and req_valid_i = 1) or REQ; 0 in DONE and in IDLE without a request.
- Minimum access, with ack on the first REQ cycle: stall for 2 cycles, done_o on the 3rd.
- Misalignment rules:
  - half with addr[0] = 1;
  - word with addr[1:0] != 00;
  - size 11 is always illegal.
- Byte enables and store data, with k = addr[1:0]:
  - byte: be = 1 << k, wdata = {4{wdata_i[7:0]}}.
  - half: be = 0011 (k = 0) or 1100 (k = 2), wdata = {2{wdata_i[15:0]}}.
  - word: be = 1111, wdata = wdata_i.
  - mem_we_o = we_i, latched.
- Load formatting: select byte lane k or half lane k[1], then extend to 32 bits per sign_ext_i. Word loads pass through unchanged.
- Output holding: rdata_o keeps its value until the next load completion or error. err_* flags are 1 only in the done_o cycle.
- mem_ack_i is ignored outside REQ.
- The timeout counter is 0 on entry to REQ and increments every REQ cycle without an ack.

Test Plan:
- Word store: addr=0x100, wdata=0xDEADBEEF, ack after 3 cycles -> mem_addr_o=0x100, be=1111, stall_o high 4 cycles, done_o once, no error.
- Byte load, signed: addr=0x103, sign_ext=1, mem_rdata=0x80xxxxxx, immediate ack -> rdata_o=0xFFFFFF80; repeat with sign_ext=0 -> 0x00000080.
- Half store: addr=0x42, wdata=0x1234ABCD -> mem_addr_o=0x40, be=1100, mem_wdata_o=0xABCDABCD.
- Misaligned word load: addr=0x101 -> mem_req_o never asserted, done_o and err_misalign_o high on the 2nd cycle, rdata_o=0.
- Timeout: TIMEOUT_CYCLES=4, no ack -> mem_req_o high exactly 4 cycles, then done_o and err_timeout_o. Ack in the 4th REQ cycle -> normal completion, no error.
- Reset mid-REQ: rst_ni low during the 2nd REQ cycle -> mem_req_o and stall-related state cleared immediately, no done_o. A new request after reset completes normally.
